ppm_frame_scheduler: RTL and testbench

- Frame-level controller that sequences the PPM transmit datapath.
- Accepts payload bytes from upstream over a valid/ready handshake and buffers one frame (up to DEPTH bytes) internally.
- Drives the symbol-type, symbol-cycle-counter, bit-pair index and current byte that the PPM transmit stage uses to emit SOF, DATA symbols and EOF.
- Sits between the serial-to-parallel front end and the PPM transmit stage, replacing ad-hoc sequencing in the top level.

---
 rtl/ppm_frame_scheduler.sv | 122 ++++++++++++
 tb/tb_ppm_frame_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ppm_frame_scheduler.sv
// ppm_frame_scheduler: buffers one payload frame and sequences SOF/DATA/EOF/GAP for the PPM transmitter (optional abort via PPM_FRAME_SCHEDULER_ABORT_EN)
module ppm_frame_scheduler #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
`ifdef PPM_FRAME_SCHEDULER_ABORT_EN
    input  logic       abort,
`endif
    output logic       in_ready,
    output logic [1:0] order,
    output logic [9:0] sym_cnt,
    output logic [1:0] bit_cnt,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       frame_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [9:0] GAP_LAST = 10'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    typedef enum logic [2:0] {IDLE, SOF, DATA, EOF, GAP} state_t;
    state_t      state, state_nxt;
    logic [9:0]  sym_cnt_nxt;
    logic [1:0]  bit_cnt_nxt;
    logic [7:0]  tx_byte_nxt;
    logic [AW:0] wr_count, wr_count_nxt;
    logic [AW-1:0] rd_ptr, rd_ptr_nxt;
    logic [7:0]  mem [DEPTH];
    logic        accept, abort_i, last_byte;
`ifdef PPM_FRAME_SCHEDULER_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif
    assign in_ready   = state == IDLE && wr_count < (AW+1)'(DEPTH);
    assign accept     = in_valid && in_ready;
    assign busy       = state != IDLE;
    assign order      = state == SOF ? 2'b01 : state == DATA ? 2'b10 : state == EOF ? 2'b11 : 2'b00;
    assign last_byte  = {1'b0, rd_ptr} == wr_count - (AW+1)'(1);
    assign frame_done = GAP_CYCLES == 0 ? (state == EOF && sym_cnt == 10'd63)
                                        : (state == GAP && sym_cnt == GAP_LAST);
    // Payload buffer; discarding a frame only needs wr_count cleared, so no reset here
    always_ff @(posedge clk) begin
        if (accept && !abort_i) mem[wr_count[AW-1:0]] <= in_data;
    end
    // Next-state and next-counter logic; abort overrides SOF/DATA progress
    always_comb begin
        state_nxt    = state;
        sym_cnt_nxt  = sym_cnt + 10'd1;
        bit_cnt_nxt  = bit_cnt;
        tx_byte_nxt  = tx_byte;
        wr_count_nxt = wr_count;
        rd_ptr_nxt   = rd_ptr;
        case (state)
            IDLE: begin
                sym_cnt_nxt = '0;
                if (abort_i) wr_count_nxt = '0;
                else if (accept) begin
                    wr_count_nxt = wr_count + (AW+1)'(1);
                    if (in_last || wr_count == (AW+1)'(DEPTH - 1)) state_nxt = SOF;
                end
            end
            SOF: if (sym_cnt == 10'd127) begin
                state_nxt   = DATA;
                sym_cnt_nxt = '0;
                bit_cnt_nxt = '0;
                rd_ptr_nxt  = '0;
                tx_byte_nxt = mem[0];
            end
            DATA: if (sym_cnt == 10'd127) begin
                sym_cnt_nxt = '0;
                bit_cnt_nxt = bit_cnt + 2'd1;
                if (bit_cnt == 2'd3) begin
                    rd_ptr_nxt  = rd_ptr + AW'(1);
                    tx_byte_nxt = mem[rd_ptr + AW'(1)];
                    if (last_byte) state_nxt = EOF;
                end
            end
            EOF: if (sym_cnt == 10'd63) begin
                sym_cnt_nxt = '0;
                state_nxt   = GAP_CYCLES == 0 ? IDLE : GAP;
                if (GAP_CYCLES == 0) begin
                    wr_count_nxt = '0;
                    rd_ptr_nxt   = '0;
                end
            end
            GAP: if (sym_cnt == GAP_LAST) begin
                state_nxt    = IDLE;
                sym_cnt_nxt  = '0;
                wr_count_nxt = '0;
                rd_ptr_nxt   = '0;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_i && (state == SOF || state == DATA)) begin
            state_nxt   = EOF;
            sym_cnt_nxt = '0;
            bit_cnt_nxt = '0;
        end
    end
    // State and counter registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sym_cnt  <= '0;
            bit_cnt  <= '0;
            tx_byte  <= '0;
            wr_count <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            sym_cnt  <= sym_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            tx_byte  <= tx_byte_nxt;
            wr_count <= wr_count_nxt;
            rd_ptr   <= rd_ptr_nxt;
        end
    end
endmodule

// File: tb/tb_ppm_frame_scheduler.sv
// tb_ppm_frame_scheduler: randomized frames against a frame-level reference model with a decoupled monitor
module tb_ppm_frame_scheduler;
    localparam int DEPTH = 16;
    localparam int GAP   = 64;
    logic       clk = 0, rst = 0;
    logic [7:0] in_data = 0;
    logic       in_valid = 0, in_last = 0;
    logic       in_ready, busy, frame_done;
    logic [1:0] order, bit_cnt;
    logic [9:0] sym_cnt;
    logic [7:0] tx_byte;
`ifdef PPM_FRAME_SCHEDULER_ABORT_EN
    logic abort = 0;
`endif
    int errors = 0, checks = 0, cyc = 0, last_fd_cyc = -1;
    logic [7:0] cur[$], exp_bytes[$], obs[$];
    int exp_len[$], exp_dlen[$];
    int sof_len, dlen, eof_len, gap_len, viol;
    logic [7:0] cur_b;

    ppm_frame_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
`ifdef PPM_FRAME_SCHEDULER_ABORT_EN
        .abort(abort),
`endif
        .in_ready(in_ready), .order(order), .sym_cnt(sym_cnt), .bit_cnt(bit_cnt),
        .tx_byte(tx_byte), .busy(busy), .frame_done(frame_done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a frame closes on in_last or when DEPTH bytes are held
    task automatic model_accept(input logic [7:0] d, input logic l);
        cur.push_back(d);
        if (l || cur.size() == DEPTH) begin
            exp_len.push_back(cur.size());
            exp_dlen.push_back(512 * cur.size());
            foreach (cur[i]) exp_bytes.push_back(cur[i]);
            cur.delete();
        end
    endtask

    // Called just after a negedge; offers one byte until the handshake completes
    task automatic push_byte(input logic [7:0] d, input logic l, input int gap, output int acc);
        int t = 0;
        repeat (gap) begin
            in_valid = 0;
            in_last  = 1'($urandom);
            @(negedge clk);
        end
        in_data = d; in_last = l; in_valid = 1;
        while (!in_ready) begin
            @(negedge clk);
            t++;
            if (t > 20000) begin
                $display("FAIL handshake_timeout: got no in_ready expected in_ready=1");
                $fatal(1);
            end
        end
        acc = cyc;
        model_accept(d, l);
        @(negedge clk);
        in_valid = 0; in_last = 0;
    endtask

    task automatic send_frame(input int n, input logic use_last, input int maxgap);
        int acc;
        for (int i = 0; i < n; i++)
            push_byte(8'($urandom), use_last && i == n - 1, $urandom_range(0, maxgap), acc);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_len.size() != 0 && t < 30000) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending_frames", exp_len.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_data();
        int t = 0;
        while (order != 2'b10 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("reach_data_order", order, 2'b10);
    endtask

    // Monitor: measures each frame's phases and bytes, compares at frame_done
    always @(negedge clk) begin
        if (!rst) begin
            sof_len = 0; dlen = 0; eof_len = 0; gap_len = 0; viol = 0; obs.delete();
        end else begin
            if (busy == in_ready) viol++;
            if (order != 2'b00 && !busy) viol++;
            if (order != 2'b10 && bit_cnt != 0) viol++;
            case (order)
                2'b01: begin if (int'(sym_cnt) != sof_len) viol++; sof_len++; end
                2'b10: begin
                    if (int'(sym_cnt) != dlen % 128 || int'(bit_cnt) != (dlen / 128) % 4) viol++;
                    if (dlen % 512 == 0) begin cur_b = tx_byte; obs.push_back(tx_byte); end
                    else if (tx_byte != cur_b) viol++;
                    dlen++;
                end
                2'b11: begin if (int'(sym_cnt) != eof_len) viol++; eof_len++; end
                default: if (busy) begin
                    if (int'(sym_cnt) != gap_len) viol++;
                    gap_len++;
                end else if (sym_cnt != 0) viol++;
            endcase
            if (frame_done) begin
                last_fd_cyc = cyc;
                if (exp_len.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame_done: got pulse expected none");
                end else begin
                    int n, dl;
                    n = exp_len.pop_front();
                    dl = exp_dlen.pop_front();
                    check("sof_cycles", sof_len, 128);
                    check("data_cycles", dlen, dl);
                    check("eof_cycles", eof_len, 64);
                    check("gap_cycles", gap_len, GAP);
                    check("byte_count", obs.size(), n);
                    for (int i = 0; i < n; i++) begin
                        logic [7:0] b;
                        b = exp_bytes.pop_front();
                        if (i < obs.size()) check("tx_byte", obs[i], b);
                    end
                    check("cycle_shape_violations", viol, 0);
                end
                sof_len = 0; dlen = 0; eof_len = 0; gap_len = 0; viol = 0; obs.delete();
            end
        end
    end

    initial begin
        int acc;
        #2;
        check("rst_order", order, 0);
        check("rst_sym_cnt", sym_cnt, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk); @(negedge clk);
        rst = 1;
        @(negedge clk);
        push_byte(8'hB4, 1, 0, acc);
        drain();
        push_byte(8'h11, 0, 1, acc);
        push_byte(8'h22, 0, 2, acc);
        push_byte(8'h33, 1, 0, acc);
        drain();
        send_frame(DEPTH, 0, 1);
        drain();
        send_frame(3, 1, 0);
        push_byte(8'($urandom), 0, 0, acc);
        check("b2b_first_accept_cycle", acc, last_fd_cyc + 1);
        push_byte(8'($urandom), 1, 0, acc);
        drain();
        push_byte(8'hA5, 0, 0, acc);
        push_byte(8'h5A, 1, 0, acc);
        wait_data();
        repeat (300) @(negedge clk);
        #3 rst = 0;
        exp_len.delete(); exp_dlen.delete(); exp_bytes.delete(); cur.delete();
        #1;
        check("async_rst_order", order, 0);
        check("async_rst_tx_byte", tx_byte, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_sym_cnt", sym_cnt, 0);
        @(negedge clk); @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        push_byte(8'h3C, 1, 0, acc);
        drain();
        for (int f = 0; f < 6; f++) begin
            send_frame($urandom_range(1, 5), 1, 3);
            drain();
        end
`ifdef PPM_FRAME_SCHEDULER_ABORT_EN
        send_frame(2, 0, 0);
        abort = 1;
        @(negedge clk);
        abort = 0;
        cur.delete();
        push_byte(8'hC3, 1, 0, acc);
        drain();
        send_frame(4, 1, 0);
        wait_data();
        repeat (600) @(negedge clk);
        abort = 1;
        void'(exp_len.pop_back());
        void'(exp_dlen.pop_back());
        void'(exp_bytes.pop_back());
        void'(exp_bytes.pop_back());
        exp_len.push_back(2);
        exp_dlen.push_back(601);
        @(negedge clk);
        abort = 0;
        drain();
`endif
        check("leftover_expected_bytes", exp_bytes.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
